mtm_alu_ctrl: RTL and testbench
===============================

Name: mtm_alu_ctrl

Overview:
Byte-stream front/back-end controller that sequences the mtm_Alu_core datapath. It collects an operand frame from a byte stream, checks frame format, CRC4 and opcode, and issues one operation, or a pre-classified error code, to the core. It captures the core's registered result and returns it as a response byte stream. It sits between the serial deserializer/serializer glue and the core, and owns the core's A, B and CTL_in inputs.

Parameters:
DATA_BYTES, 8, number of data bytes per frame: B[31:0] then A[31:0], each MSB byte first. Fixed at 8; exists only for assertion and readability.

Ports:
clk  input  1  system clock, all state updates on posedge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  input byte present
in_ready  output  1  controller accepts in_data this cycle
in_data  input  8  input byte
in_is_ctl  input  1  1 = control byte {1'b0, OP[2:0], CRC4[3:0]}; 0 = data byte
out_valid  output  1  response byte present
out_ready  input  1  downstream accepts out_data
out_data  output  8  response byte
out_is_ctl  output  1  1 = response control/status byte
core_A  output  32  to core A
core_B  output  32  to core B
core_CTL_in  output  8  to core CTL_in; 8'hFF when idle
core_C  input  32  from core C
core_CTL_out  input  8  from core CTL_out

Behaviour:
- Reset (rst_n=0 at posedge): state=COLLECT; byte count=0; in_ready=0 during the reset cycle, then 1; out_valid=0; out_data=0; out_is_ctl=0; core_A=core_B=0; core_CTL_in=8'hFF. Reset mid-frame or mid-send discards everything. There is no partial output.
- Input handshake: a byte transfers on a posedge with in_valid & in_ready. in_ready=1 only in COLLECT and DISCARD.
- COLLECT:
  - Data byte: shift into a 64-bit register, count+1. The first 4 bytes form B and the next 4 form A, MSB byte first.
  - Ctl byte with count==8: classify, then go to ISSUE.
  - Ctl byte with count<8: code=ERR_DATA (8'hC9), go to ISSUE.
  - Data byte with count==8 (9th data byte): go to DISCARD.
- DISCARD: drop data bytes. The next ctl byte is consumed and ends the frame with code=ERR_DATA; go to ISSUE.
- Classification priority: ERR_DATA > ERR_CRC (8'hA5) > ERR_OP (8'h93) > valid.
  - CRC4 is computed over the 68 bits {B, A, 1'b1, OP}, MSB first. Init 4'b0000. Per bit d: fb = crc[3]^d; crc = {crc[2:0],1'b0} ^ (fb ? 4'b0011 : 4'b0000).
  - A mismatch with ctl[3:0] gives ERR_CRC.
  - OP not in {000, 001, 100, 101} gives ERR_OP.
  - Valid frame: code = {1'b0, OP, CRC4}; must never equal an error code or 8'hFF.
- ISSUE (1 cycle): core_A/core_B/core_CTL_in hold frame values. The core registers them at the end of this cycle.
- CAPTURE (1 cycle): core_C/core_CTL_out are valid. Latch them into the response buffer, restore core_CTL_in=8'hFF, go to SEND.
- SEND:
  - Normal result: 5 bytes C[31:24], C[23:16], C[15:8], C[7:0] (out_is_ctl=0), then CTL_out (out_is_ctl=1).
  - Error code returned by the core: 1 byte CTL_out (out_is_ctl=1).
  - out_data/out_is_ctl are stable while out_valid & !out_ready. A byte advances on out_valid & out_ready.
  - After the last byte: out_valid=0 next cycle, state=COLLECT, count=0.
- Latency: ctl byte accepted at edge k; first out_valid=1 in the cycle after edge k+3. Throughput is one frame in flight; no input is accepted during ISSUE, CAPTURE and SEND.
- core_A/core_B hold their last values when idle. They are cleared only by reset.

Test Plan:
- B=0, A=0, ctl=8'h0B (OP=AND, CRC4=4'b1011) -> 5 bytes 00,00,00,00 then 8'h16 (out_is_ctl=1). core_CTL_in=8'h0B for exactly one cycle.
- B=1, A=2, OP=ADD, ctl CRC deliberately wrong -> single byte 8'hA5 (out_is_ctl=1). No data bytes are emitted.
- 8 data bytes + ctl OP=3'b010 with correct CRC4 -> single byte 8'h93. A case with both a wrong CRC and a bad OP -> 8'hA5.
- 5 data bytes then ctl -> 8'hC9. 10 data bytes then ctl -> in_ready stays 1 and all bytes are consumed, then 8'hC9. The next legal frame returns a correct result.
- B=32'h00000001, A=32'hFFFFFFFF, OP=ADD, hold out_ready=0 for 4 cycles per byte -> bytes 00,00,00,00 then core CTL_out (Carry=1, Zero=1). Bytes are stable under stall; in_ready=0 until the last byte is accepted.
- rst_n=0 asserted during SEND after 2 bytes -> next cycle out_valid=0 and core_CTL_in=8'hFF. A new frame is processed normally.

Source files
------------

// File: rtl/mtm_alu_ctrl.sv
// Byte-stream controller for the mtm_Alu_core datapath.
// Collects B/A operand frames plus a control byte, classifies them, issues
// one operation (or error code) to the core and streams the result back.
module mtm_alu_ctrl #(
    parameter int DATA_BYTES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_is_ctl,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_is_ctl,
    output logic [31:0] core_A,
    output logic [31:0] core_B,
    output logic [7:0]  core_CTL_in,
    input  logic [31:0] core_C,
    input  logic [7:0]  core_CTL_out
);

    typedef enum logic [2:0] {COLLECT, DISCARD, ISSUE, CAPTURE, SEND} state_t;

    localparam logic [7:0] ERR_DATA = 8'hC9;
    localparam logic [7:0] ERR_CRC  = 8'hA5;
    localparam logic [7:0] ERR_OP   = 8'h93;
    localparam logic [7:0] CTL_IDLE = 8'hFF;
    localparam logic [3:0] FULL     = 4'(DATA_BYTES);

    state_t      state;
    logic [3:0]  cnt;
    logic [63:0] shreg;
    logic [31:0] resp_c;
    logic [7:0]  resp_ctl;
    logic [1:0]  byte_idx;

    logic [67:0] crc_msg;
    logic        crc_fb;
    logic [3:0]  crc_calc;
    logic        op_ok;
    logic [7:0]  frame_code;

    // CRC4 over {B, A, 1'b1, OP}, MSB first, evaluated against the incoming ctl byte
    always_comb begin
        crc_calc = '0;
        crc_fb   = 1'b0;
        crc_msg  = {shreg, 1'b1, in_data[6:4]};
        for (int unsigned i = 0; i < 68; i++) begin
            crc_fb   = crc_calc[3] ^ crc_msg[67];
            crc_calc = {crc_calc[2:0], 1'b0} ^ (crc_fb ? 4'b0011 : 4'b0000);
            crc_msg  = {crc_msg[66:0], 1'b0};
        end
    end

    // Frame classification: data error > CRC error > opcode error > valid
    always_comb begin
        op_ok = (in_data[6:4] == 3'b000) || (in_data[6:4] == 3'b001) ||
                (in_data[6:4] == 3'b100) || (in_data[6:4] == 3'b101);
        // a ctl byte with its MSB set is malformed and treated as a data error
        if ((cnt != FULL) || in_data[7])
            frame_code = ERR_DATA;
        else if (crc_calc != in_data[3:0])
            frame_code = ERR_CRC;
        else if (!op_ok)
            frame_code = ERR_OP;
        else
            frame_code = {1'b0, in_data[6:0]};
    end

    // Frame sequencer with registered handshake and core outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= COLLECT;
            cnt         <= '0;
            shreg       <= '0;
            resp_c      <= '0;
            resp_ctl    <= '0;
            byte_idx    <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_is_ctl  <= 1'b0;
            core_A      <= '0;
            core_B      <= '0;
            core_CTL_in <= CTL_IDLE;
        end else begin
            case (state)
                COLLECT: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (in_is_ctl) begin
                            core_B      <= shreg[63:32];
                            core_A      <= shreg[31:0];
                            core_CTL_in <= frame_code;
                            in_ready    <= 1'b0;
                            state       <= ISSUE;
                        end else if (cnt == FULL) begin
                            state <= DISCARD;
                        end else begin
                            shreg <= {shreg[55:0], in_data};
                            cnt   <= cnt + 4'd1;
                        end
                    end
                end
                DISCARD: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready && in_is_ctl) begin
                        core_B      <= shreg[63:32];
                        core_A      <= shreg[31:0];
                        core_CTL_in <= ERR_DATA;
                        in_ready    <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // core samples at this edge, so the idle code returns here and
                    // the frame code is visible for exactly one cycle
                    core_CTL_in <= CTL_IDLE;
                    state       <= CAPTURE;
                end
                CAPTURE: begin
                    resp_c   <= core_C;
                    resp_ctl <= core_CTL_out;
                    byte_idx <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        if (resp_ctl[7]) begin
                            out_data   <= resp_ctl;
                            out_is_ctl <= 1'b1;
                        end else begin
                            out_data   <= resp_c[31:24];
                            out_is_ctl <= 1'b0;
                        end
                    end else if (out_ready) begin
                        if (out_is_ctl) begin
                            out_valid  <= 1'b0;
                            out_data   <= '0;
                            out_is_ctl <= 1'b0;
                            cnt        <= '0;
                            in_ready   <= 1'b1;
                            state      <= COLLECT;
                        end else if (byte_idx == 2'd3) begin
                            out_data   <= resp_ctl;
                            out_is_ctl <= 1'b1;
                        end else begin
                            out_data <= resp_c[23:16];
                            resp_c   <= {resp_c[23:0], 8'h00};
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_alu_ctrl.sv
// Self-checking bench for mtm_alu_ctrl: behavioural core model, frame-level
// reference model and a per-cycle compare process.
module tb_mtm_alu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, in_is_ctl;
    logic [7:0]  in_data;
    logic        out_valid, out_ready, out_is_ctl;
    logic [7:0]  out_data;
    logic [31:0] core_A, core_B, core_C;
    logic [7:0]  core_CTL_in, core_CTL_out;

    mtm_alu_ctrl #(.DATA_BYTES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_is_ctl(in_is_ctl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_is_ctl(out_is_ctl),
        .core_A(core_A), .core_B(core_B), .core_CTL_in(core_CTL_in),
        .core_C(core_C), .core_CTL_out(core_CTL_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  code;
        bit          ab_chk;
        logic [31:0] a;
        logic [31:0] b;
    } issue_t;

    issue_t      code_q[$];
    logic [8:0]  byte_q[$];
    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // CRC4 as the remainder of M(x)*x^4 divided by x^4+x+1
    function automatic logic [3:0] model_crc(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op);
        logic [71:0] r;
        r = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r = r ^ (72'h13 << (i - 4));
        return r[3:0];
    endfunction

    function automatic logic [7:0] model_code(input int unsigned n, input logic [31:0] b, input logic [31:0] a,
                                              input logic [2:0] op, input logic [3:0] crcf);
        if (n != 8) return 8'hC9;
        if (crcf != model_crc(b, a, op)) return 8'hA5;
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5)) return 8'h93;
        return {1'b0, op, crcf};
    endfunction

    // Core behaviour: {C, CTL_out}; error/idle codes are echoed back
    function automatic logic [39:0] core_eval(input logic [7:0] ctl, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] c;
        logic        cy, ov;
        logic [3:0]  fl;
        logic [39:0] m;
        if (ctl[7]) return {32'h0, ctl};
        cy = 1'b0; ov = 1'b0; c = '0; s = '0;
        case (ctl[6:4])
            3'b000: c = b & a;
            3'b001: c = b | a;
            3'b100: begin
                s = {1'b0, b} + {1'b0, a}; c = s[31:0]; cy = s[32];
                ov = (a[31] == b[31]) && (c[31] != a[31]);
            end
            3'b101: begin
                s = {1'b0, b} - {1'b0, a}; c = s[31:0]; cy = s[32];
                ov = (a[31] != b[31]) && (c[31] != b[31]);
            end
            default: c = '0;
        endcase
        fl = {cy, ov, (c == 32'h0), c[31]};
        m = {c, 1'b0, fl, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (m[i]) m = m ^ (40'hB << (i - 3));
        return {c, 1'b0, fl, m[2:0]};
    endfunction

    always @(posedge clk) begin
        {core_C, core_CTL_out} <= core_eval(core_CTL_in, core_A, core_B);
    end

    int rmode = 2;
    int stall_cnt = 0;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: out_ready = ($urandom_range(0, 3) != 0);
                1: begin
                    out_ready = (stall_cnt == 4);
                    stall_cnt = (stall_cnt == 4) ? 0 : stall_cnt + 1;
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    bit armed = 0, after_reset = 0, exp_ready = 0, exp_valid = 0, lat_on = 0;
    int lat = 0;

    always @(negedge clk) begin
        if (armed) begin
            if (after_reset) begin
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_out_data", 64'(out_data), 64'd0);
                chk("rst_out_is_ctl", 64'(out_is_ctl), 64'd0);
                chk("rst_in_ready", 64'(in_ready), 64'd0);
                chk("rst_core_ctl_in", 64'(core_CTL_in), 64'hFF);
                chk("rst_core_a", 64'(core_A), 64'd0);
                chk("rst_core_b", 64'(core_B), 64'd0);
            end else begin
                chk("in_ready", 64'(in_ready), 64'(exp_ready));
                chk("out_valid", 64'(out_valid), 64'(exp_valid));
                if (exp_valid && byte_q.size() > 0) begin
                    chk("out_data", 64'(out_data), 64'(byte_q[0][7:0]));
                    chk("out_is_ctl", 64'(out_is_ctl), 64'(byte_q[0][8]));
                end
                if (lat_on && lat == 1) begin
                    chk("issue_pending", 64'(code_q.size()), 64'd1);
                    if (code_q.size() > 0) begin
                        chk("core_ctl_in", 64'(core_CTL_in), 64'(code_q[0].code));
                        if (code_q[0].ab_chk) begin
                            chk("core_a", 64'(core_A), 64'(code_q[0].a));
                            chk("core_b", 64'(core_B), 64'(code_q[0].b));
                        end
                    end
                end else begin
                    chk("core_ctl_idle", 64'(core_CTL_in), 64'hFF);
                end
            end
        end
        if (!rst_n) begin
            armed = 1; after_reset = 1; exp_ready = 0; exp_valid = 0;
            lat_on = 0; lat = 0;
            byte_q.delete(); code_q.delete();
        end else if (armed) begin
            if (after_reset) begin
                after_reset = 0;
                exp_ready = 1;
            end
            if (lat_on) begin
                if (lat == 1 && code_q.size() > 0) void'(code_q.pop_front());
                lat++;
                if (lat == 4) begin
                    lat_on = 0;
                    exp_valid = 1;
                end
            end
            if (in_valid && in_ready && in_is_ctl && exp_ready) begin
                lat_on = 1; lat = 1; exp_ready = 0;
            end
            if (exp_valid && out_valid && out_ready && byte_q.size() > 0) begin
                void'(byte_q.pop_front());
                if (byte_q.size() == 0) begin
                    exp_valid = 0;
                    exp_ready = 1;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic c, input bit gaps);
        int unsigned n;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_data = d; in_is_ctl = c; n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        chk("in_accept_bound", 64'(n < 300), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_is_ctl = 1'b0; in_data = 8'($urandom);
    endtask

    task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                              input logic [3:0] crc_err, input int unsigned nbytes, input bit gaps);
        logic [63:0] payload;
        logic [3:0]  crcf;
        logic [7:0]  code;
        logic [39:0] r;
        issue_t      it;
        payload = {b, a};
        crcf = model_crc(b, a, op) ^ crc_err;
        code = model_code(nbytes, b, a, op, crcf);
        it.code = code; it.ab_chk = (nbytes == 8); it.a = a; it.b = b;
        code_q.push_back(it);
        if (code[7]) begin
            byte_q.push_back({1'b1, code});
        end else begin
            r = core_eval(code, a, b);
            byte_q.push_back({1'b0, r[39:32]});
            byte_q.push_back({1'b0, r[31:24]});
            byte_q.push_back({1'b0, r[23:16]});
            byte_q.push_back({1'b0, r[15:8]});
            byte_q.push_back({1'b1, r[7:0]});
        end
        for (int unsigned i = 0; i < nbytes; i++) begin
            if (i < 8) begin
                send_byte(payload[63:56], 1'b0, gaps);
                payload = {payload[55:0], 8'h00};
            end else begin
                send_byte(8'($urandom), 1'b0, gaps);
            end
        end
        send_byte({1'b0, op, crcf}, 1'b1, gaps);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        @(negedge clk);
        while (!(byte_q.size() == 0 && code_q.size() == 0 && !lat_on && !exp_valid && in_ready) && n < 500) begin
            @(negedge clk); n++;
        end
        chk("frame_done_bound", 64'(n < 500), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [39:0] r;
        int unsigned n;
        int unsigned nb;
        in_valid = 1'b0; in_data = '0; in_is_ctl = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // hand-computed values pinning the reference model
        chk("pin_crc_zero_and", 64'(model_crc(32'h0, 32'h0, 3'b000)), 64'hB);
        chk("pin_crc_add_1_2", 64'(model_crc(32'h1, 32'h2, 3'b100)), 64'hA);
        chk("pin_code_short", 64'(model_code(5, 32'h0, 32'h0, 3'b000, 4'hB)), 64'hC9);
        r = core_eval(8'h0B, 32'h0, 32'h0);
        chk("pin_core_and_zero", 64'(r), 64'h16);
        r = core_eval({1'b0, 3'b100, model_crc(32'h1, 32'hFFFFFFFF, 3'b100)}, 32'hFFFFFFFF, 32'h1);
        chk("pin_core_add_flags", 64'({r[39:8], r[6:3]}), 64'hA);

        send_frame(32'h0, 32'h0, 3'b000, 4'h0, 8, 0);                 wait_idle();
        send_frame(32'h1, 32'h2, 3'b100, 4'h5, 8, 0);                 wait_idle();
        send_frame(32'h12345678, 32'h9ABCDEF0, 3'b010, 4'h0, 8, 0);   wait_idle();
        send_frame(32'h12345678, 32'h9ABCDEF0, 3'b011, 4'h3, 8, 0);   wait_idle();
        send_frame(32'hAABBCCDD, 32'h11223344, 3'b001, 4'h0, 5, 0);   wait_idle();
        send_frame(32'hAABBCCDD, 32'h11223344, 3'b001, 4'h0, 10, 0);  wait_idle();
        send_frame(32'h0000FFFF, 32'h00000F0F, 3'b101, 4'h0, 8, 0);   wait_idle();

        rmode = 1; stall_cnt = 0;
        send_frame(32'h00000001, 32'hFFFFFFFF, 3'b100, 4'h0, 8, 0);   wait_idle();
        rmode = 2;

        send_frame($urandom, $urandom, 3'b100, 4'h0, 8, 0);
        n = 0;
        @(negedge clk);
        while (byte_q.size() > 3 && n < 200) begin @(negedge clk); n++; end
        chk("send_progress_bound", 64'(n < 200), 64'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        send_frame(32'h00000010, 32'h00000020, 3'b100, 4'h0, 8, 0);   wait_idle();

        rmode = 0;
        for (int k = 0; k < 40; k++) begin
            nb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 11) : 8;
            send_frame($urandom, $urandom, 3'($urandom_range(0, 7)),
                       ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0, nb, 1);
            wait_idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
